// File: rtl/pri_encoder_seq.sv
// ----------------------------------------------------------------------------
// pri_encoder_seq
//   Registered N:log2(N) priority encoder with sticky request capture and a
//   valid/ready output handshake. Request pulses are collected into a pending
//   vector; one encoded index is issued per handshake, highest priority first.
//
// Parameters
//   N          number of request lines (N >= 2)
//   MSB_FIRST  1: highest set index wins; 0: lowest set index wins
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   req_in     in   N      request lines, single-cycle pulses are captured
//   req_mask   in   N      selection mask (only with PRI_ENC_MASK_EN)
//   clr        in   1      synchronous flush of pending requests and output
//   out_ready  in   1      consumer accepts out_idx
//   out_valid  out  1      out_idx is valid
//   out_idx    out  IDX_W  encoded index of the selected request
//   pend       out  N      registered pending-request vector
//
// Build option
//   PRI_ENC_MASK_EN  adds req_mask; masked bits are captured but not selected.
// ----------------------------------------------------------------------------
module pri_encoder_seq #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_in,
`ifdef PRI_ENC_MASK_EN
    input  logic [N-1:0]         req_mask,
`endif
    input  logic                 clr,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_idx,
    output logic [N-1:0]         pend
);

    localparam int IDX_W = $clog2(N);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [N-1:0]       r_pend;
    logic [N-1:0]       w_pend_nxt;
    logic [N-1:0]       w_mask;
    logic [N-1:0]       w_idx_oh;
    logic [N-1:0]       w_done;
    logic [N-1:0]       w_elig_idle;
    logic [N-1:0]       w_elig_hs;
    logic               w_hs;

    // Later hits overwrite earlier ones, so the scan direction sets priority.
    function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] v);
        logic [IDX_W-1:0] s;
        s = '0;
        if (MSB_FIRST) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (v[i]) s = IDX_W'(i);
            end
        end else begin
            for (int unsigned i = N; i > 0; i--) begin
                if (v[i-1]) s = IDX_W'(i - 1);
            end
        end
        return s;
    endfunction

`ifdef PRI_ENC_MASK_EN
    assign w_mask = req_mask;
`else
    assign w_mask = '0;
`endif

    assign w_idx_oh    = N'(1) << r_idx;
    assign w_hs        = r_valid & out_ready;
    assign w_done      = w_hs ? w_idx_oh : '0;
    // Set wins: a bit re-requested in its own handshake cycle stays pending.
    assign w_pend_nxt  = (r_pend & ~w_done) | req_in;
    assign w_elig_idle = r_pend & ~w_mask;
    // Next grant after a handshake sees registered P minus the granted bit only;
    // same-cycle arrivals wait a cycle.
    assign w_elig_hs   = r_pend & ~w_idx_oh & ~w_mask;

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                if (w_elig_idle != '0) begin
                    w_idx_nxt   = pick(w_elig_idle);
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_valid_nxt = 1'b1;
                if (w_hs) begin
                    if (w_elig_hs != '0) begin
                        w_idx_nxt = pick(w_elig_hs);
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_idx   <= w_idx_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign pend      = r_pend;

endmodule

// File: tb/tb_pri_encoder_seq.sv
// ----------------------------------------------------------------------------
// tb_pri_encoder_seq
//   Directed bench for pri_encoder_seq. Two instances share the inputs: one
//   with MSB_FIRST=1 (u_msb) and one with MSB_FIRST=0 (u_lsb).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_pri_encoder_seq;

    logic       clk;
    logic       rst;
    logic [7:0] req_in;
    logic [7:0] req_mask;
    logic       clr;
    logic       out_ready;
    logic       m_valid, l_valid;
    logic [2:0] m_idx, l_idx;
    logic [7:0] m_pend, l_pend;

    int n_vec;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pri_encoder_seq #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
`ifdef PRI_ENC_MASK_EN
        .req_mask  (req_mask),
`endif
        .clr       (clr),
        .out_ready (out_ready),
        .out_valid (m_valid),
        .out_idx   (m_idx),
        .pend      (m_pend)
    );

    pri_encoder_seq #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
`ifdef PRI_ENC_MASK_EN
        .req_mask  (req_mask),
`endif
        .clr       (clr),
        .out_ready (out_ready),
        .out_valid (l_valid),
        .out_idx   (l_idx),
        .pend      (l_pend)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_in = 8'hFF; clr = 1'b0; out_ready = 1'b1; req_mask = 8'h00;
        tick();
        tick();
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", m_valid); end
        n_vec++; if (m_idx !== 3'd0) begin n_err++; $display("FAIL rst_idx got=%0d exp=0", m_idx); end
        n_vec++; if (m_pend !== 8'h00) begin n_err++; $display("FAIL rst_pend got=%h exp=00", m_pend); end
        rst = 1'b0; req_in = 8'h00;
        tick();
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_valid got=%b exp=0", m_valid); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1; req_in = 8'h06;
        tick();
        req_in = 8'h00;
        n_vec++; if (m_pend !== 8'h06) begin n_err++; $display("FAIL basic_t1_pend got=%h exp=06", m_pend); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL basic_t1_valid got=%b exp=0", m_valid); end
        tick();
        n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL basic_t2_valid got=%b exp=1", m_valid); end
        n_vec++; if (m_idx !== 3'd2) begin n_err++; $display("FAIL basic_t2_idx got=%0d exp=2", m_idx); end
        n_vec++; if (l_idx !== 3'd1) begin n_err++; $display("FAIL basic_t2_lsb_idx got=%0d exp=1", l_idx); end
        tick();
        n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL basic_t3_valid got=%b exp=1", m_valid); end
        n_vec++; if (m_idx !== 3'd1) begin n_err++; $display("FAIL basic_t3_idx got=%0d exp=1", m_idx); end
        n_vec++; if (m_pend !== 8'h02) begin n_err++; $display("FAIL basic_t3_pend got=%h exp=02", m_pend); end
        tick();
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL basic_t4_valid got=%b exp=0", m_valid); end
        n_vec++; if (m_pend !== 8'h00) begin n_err++; $display("FAIL basic_t4_pend got=%h exp=00", m_pend); end
    endtask

    task automatic test_no_preempt();
        out_ready = 1'b0; req_in = 8'h02;
        tick();
        req_in = 8'h00;
        tick();
        n_vec++; if (m_idx !== 3'd1) begin n_err++; $display("FAIL hold_idx got=%0d exp=1", m_idx); end
        req_in = 8'h80;
        tick();
        req_in = 8'h00;
        n_vec++; if (m_idx !== 3'd1) begin n_err++; $display("FAIL nopre_idx got=%0d exp=1", m_idx); end
        n_vec++; if (m_pend !== 8'h82) begin n_err++; $display("FAIL nopre_pend got=%h exp=82", m_pend); end
        tick();
        n_vec++; if (m_idx !== 3'd1 || m_valid !== 1'b1) begin n_err++; $display("FAIL nopre_stable idx=%0d valid=%b exp idx=1 valid=1", m_idx, m_valid); end
        out_ready = 1'b1;
        tick();
        n_vec++; if (m_idx !== 3'd7) begin n_err++; $display("FAIL nopre_next_idx got=%0d exp=7", m_idx); end
        n_vec++; if (m_pend !== 8'h80) begin n_err++; $display("FAIL nopre_next_pend got=%h exp=80", m_pend); end
        tick();
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL nopre_idle_valid got=%b exp=0", m_valid); end
    endtask

    task automatic test_set_wins();
        out_ready = 1'b0; req_in = 8'h08;
        tick();
        req_in = 8'h00;
        tick();
        n_vec++; if (m_idx !== 3'd3) begin n_err++; $display("FAIL setw_idx got=%0d exp=3", m_idx); end
        out_ready = 1'b1; req_in = 8'h08;
        tick();
        req_in = 8'h00;
        n_vec++; if (m_pend !== 8'h08) begin n_err++; $display("FAIL setw_pend got=%h exp=08", m_pend); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL setw_gap_valid got=%b exp=0", m_valid); end
        tick();
        n_vec++; if (m_valid !== 1'b1 || m_idx !== 3'd3) begin n_err++; $display("FAIL setw_regrant valid=%b idx=%0d exp valid=1 idx=3", m_valid, m_idx); end
        tick();
        n_vec++; if (m_valid !== 1'b0 || m_pend !== 8'h00) begin n_err++; $display("FAIL setw_done valid=%b pend=%h exp valid=0 pend=00", m_valid, m_pend); end
    endtask

    task automatic test_clr();
        out_ready = 1'b0; req_in = 8'h20;
        tick();
        req_in = 8'h00;
        tick();
        n_vec++; if (m_valid !== 1'b1 || m_idx !== 3'd5) begin n_err++; $display("FAIL clr_pre valid=%b idx=%0d exp valid=1 idx=5", m_valid, m_idx); end
        clr = 1'b1; req_in = 8'hFF; out_ready = 1'b1;
        tick();
        clr = 1'b0; req_in = 8'h00;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid got=%b exp=0", m_valid); end
        n_vec++; if (m_pend !== 8'h00) begin n_err++; $display("FAIL clr_pend got=%h exp=00", m_pend); end
        n_vec++; if (m_idx !== 3'd0) begin n_err++; $display("FAIL clr_idx got=%0d exp=0", m_idx); end
        tick();
        n_vec++; if (m_valid !== 1'b0 || m_pend !== 8'h00) begin n_err++; $display("FAIL clr_nogrant valid=%b pend=%h exp valid=0 pend=00", m_valid, m_pend); end
    endtask

    task automatic test_lsb_first();
        out_ready = 1'b1; req_in = 8'h90;
        tick();
        req_in = 8'h00;
        tick();
        n_vec++; if (l_valid !== 1'b1 || l_idx !== 3'd4) begin n_err++; $display("FAIL lsb_first valid=%b idx=%0d exp valid=1 idx=4", l_valid, l_idx); end
        n_vec++; if (m_idx !== 3'd7) begin n_err++; $display("FAIL msb_first_idx got=%0d exp=7", m_idx); end
        tick();
        n_vec++; if (l_valid !== 1'b1 || l_idx !== 3'd7) begin n_err++; $display("FAIL lsb_second valid=%b idx=%0d exp valid=1 idx=7", l_valid, l_idx); end
        n_vec++; if (m_idx !== 3'd4) begin n_err++; $display("FAIL msb_second_idx got=%0d exp=4", m_idx); end
        tick();
        n_vec++; if (l_valid !== 1'b0 || l_pend !== 8'h00) begin n_err++; $display("FAIL lsb_done valid=%b pend=%h exp valid=0 pend=00", l_valid, l_pend); end
    endtask

`ifdef PRI_ENC_MASK_EN
    task automatic test_mask();
        out_ready = 1'b1; req_mask = 8'h80; req_in = 8'h90;
        tick();
        req_in = 8'h00;
        tick();
        n_vec++; if (l_valid !== 1'b1 || l_idx !== 3'd4) begin n_err++; $display("FAIL mask_grant valid=%b idx=%0d exp valid=1 idx=4", l_valid, l_idx); end
        tick();
        n_vec++; if (l_valid !== 1'b0 || l_pend !== 8'h80) begin n_err++; $display("FAIL mask_held valid=%b pend=%h exp valid=0 pend=80", l_valid, l_pend); end
        tick();
        n_vec++; if (l_valid !== 1'b0) begin n_err++; $display("FAIL mask_idle valid=%b exp=0", l_valid); end
        req_mask = 8'h00;
        tick();
        n_vec++; if (l_valid !== 1'b1 || l_idx !== 3'd7) begin n_err++; $display("FAIL mask_release valid=%b idx=%0d exp valid=1 idx=7", l_valid, l_idx); end
        tick();
        n_vec++; if (l_valid !== 1'b0 || l_pend !== 8'h00) begin n_err++; $display("FAIL mask_done valid=%b pend=%h exp valid=0 pend=00", l_valid, l_pend); end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_no_preempt();
        test_set_wins();
        test_clr();
        test_lsb_first();
`ifdef PRI_ENC_MASK_EN
        test_mask();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
